// File: rtl/serial_feeder_pkg.sv
// serial_feeder_pkg: shared state type and count-width helper for the serial feeder
package serial_feeder_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int DEFAULT_NUM_BITS = 8;

    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int DEFAULT_CNT_W = cnt_width(DEFAULT_NUM_BITS);

endpackage

// File: rtl/serial_feeder_bit_counter.sv
// bit_counter: clearable, enableable bit counter with terminal flag at NUM_BITS-1
module bit_counter
    import serial_feeder_pkg::*;
#(
    parameter int NUM_BITS = DEFAULT_NUM_BITS,
    parameter int CW       = cnt_width(NUM_BITS)
) (
    input  logic          clk,
    input  logic          n_rst,
    input  logic          clr,
    input  logic          en,
    output logic [CW-1:0] cnt,
    output logic          last
);

    localparam logic [CW-1:0] TC = CW'(NUM_BITS - 1);

    assign last = (cnt == TC);

    // count consumed bits; clear wins over enable and the terminal value wraps to zero
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en)
            cnt <= last ? '0 : cnt + 1'b1;
    end

endmodule

// File: rtl/serial_feeder.sv
// serial_feeder: parallel-to-serial stage feeding a serial sequence detector
module serial_feeder
    import serial_feeder_pkg::*;
#(
    parameter int NUM_BITS  = DEFAULT_NUM_BITS,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_BIT  = 1'b0
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic [NUM_BITS-1:0] data_in,
    input  logic                data_valid,
    output logic                data_ready,
    input  logic                shift_enable,
    output logic                serial_out,
    output logic                busy,
    output logic                frame_done
);

    localparam int CW = cnt_width(NUM_BITS);

    state_t              state;
    logic [NUM_BITS-1:0] shreg;
    logic [NUM_BITS-1:0] shreg_next;
    logic [CW-1:0]       cnt;
    logic                last;
    logic                accept;
    logic                advance;

    assign busy       = (state == SHIFT);
    assign advance    = busy && shift_enable;
    assign frame_done = advance && last;
    assign data_ready = !busy || frame_done;
    assign accept     = data_valid && data_ready;
    assign shreg_next = MSB_FIRST ? {shreg[NUM_BITS-2:0], IDLE_BIT} : {IDLE_BIT, shreg[NUM_BITS-1:1]};
    assign serial_out = busy ? (MSB_FIRST ? shreg[NUM_BITS-1] : shreg[0]) : IDLE_BIT;

    bit_counter #(
        .NUM_BITS (NUM_BITS),
        .CW       (CW)
    ) u_cnt (
        .clk   (clk),
        .n_rst (n_rst),
        .clr   (accept),
        .en    (advance),
        .cnt   (cnt),
        .last  (last)
    );

    // frame FSM and shift register: a new word loads even on the last bit, giving gapless frames
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
            shreg <= {NUM_BITS{IDLE_BIT}};
        end else if (accept) begin
            state <= SHIFT;
            shreg <= data_in;
        end else if (advance) begin
            state <= last ? IDLE : SHIFT;
            shreg <= shreg_next;
        end
    end

endmodule

// File: tb/tb_serial_feeder.sv
// tb_serial_feeder: scoreboard bench for MSB-first and LSB-first serial feeders
module tb_serial_feeder;

    typedef struct packed {
        logic b;
        logic last;
    } ent_t;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic [7:0] data_in = '0;
    logic       data_valid = 1'b0;
    logic       shift_enable = 1'b0;
    logic       rdy_m, so_m, busy_m, fd_m;
    logic       rdy_l, so_l, busy_l, fd_l;

    int   total = 0;
    int   bad = 0;
    int   left = 0;
    ent_t qm[$];
    ent_t ql[$];

    always #5 clk = ~clk;

    serial_feeder #(.NUM_BITS(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_m (
        .clk(clk), .n_rst(n_rst), .data_in(data_in), .data_valid(data_valid),
        .data_ready(rdy_m), .shift_enable(shift_enable), .serial_out(so_m),
        .busy(busy_m), .frame_done(fd_m)
    );

    serial_feeder #(.NUM_BITS(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_l (
        .clk(clk), .n_rst(n_rst), .data_in(data_in), .data_valid(data_valid),
        .data_ready(rdy_l), .shift_enable(shift_enable), .serial_out(so_l),
        .busy(busy_l), .frame_done(fd_l)
    );

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s t=%0t act=%0h exp=%0h", n, $time, a, e);
        end
    endtask

    task automatic chk_reset_vals(input string n);
        chk({n, "_so_m"}, so_m, 0);
        chk({n, "_so_l"}, so_l, 0);
        chk({n, "_busy_m"}, busy_m, 0);
        chk({n, "_busy_l"}, busy_l, 0);
        chk({n, "_fd_m"}, fd_m, 0);
        chk({n, "_fd_l"}, fd_l, 0);
        chk({n, "_rdy_m"}, rdy_m, 1);
        chk({n, "_rdy_l"}, rdy_l, 1);
    endtask

    // model side: a word is taken when idle or when the final bit is being consumed
    task automatic step(input logic dv, input logic [7:0] d, input logic se);
        logic acc;
        data_valid = dv;
        data_in = d;
        shift_enable = se;
        @(posedge clk);
        acc = dv && (left == 0 || (left == 1 && se));
        if (left > 0 && se) left--;
        if (acc) begin
            left = 8;
            for (int i = 7; i >= 0; i--) qm.push_back('{b: d[i], last: (i == 0)});
            for (int i = 0; i < 8; i++) ql.push_back('{b: d[i], last: (i == 7)});
        end
        #1;
    endtask

    task automatic check_lane(input int l, input logic so, input logic rdy, input logic bsy, input logic fd);
        ent_t e;
        int   sz;
        string p;
        p = (l == 0) ? "m" : "l";
        sz = (l == 0) ? qm.size() : ql.size();
        chk({"busy_", p}, bsy, sz > 0);
        if (sz == 0) begin
            chk({"idle_out_", p}, so, 0);
            chk({"idle_rdy_", p}, rdy, 1);
            chk({"idle_fd_", p}, fd, 0);
        end else begin
            e = (l == 0) ? qm[0] : ql[0];
            chk({"bit_", p}, so, e.b);
            chk({"rdy_", p}, rdy, shift_enable && e.last);
            chk({"fd_", p}, fd, shift_enable && e.last);
            if (shift_enable) begin
                if (l == 0) void'(qm.pop_front());
                else void'(ql.pop_front());
            end
        end
    endtask

    // monitor: compare DUT outputs against the expected bit queues mid-cycle
    always @(negedge clk) begin
        if (!n_rst) begin
            chk_reset_vals("rst");
        end else begin
            check_lane(0, so_m, rdy_m, busy_m, fd_m);
            check_lane(1, so_l, rdy_l, busy_l, fd_l);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout t=%0t", $time);
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1 n_rst = 1'b1;
        repeat (5) step(0, 8'h00, 1);
        step(1, 8'b1101_0000, 1);
        repeat (10) step(0, 8'h00, 1);
        step(1, 8'b0000_0110, 1);
        repeat (8) step(1, 8'b1000_0000, 1);
        repeat (10) step(0, 8'h00, 1);
        step(1, 8'hB5, 1);
        repeat (3) step(0, 8'h00, 1);
        repeat (3) step(0, 8'h00, 0);
        repeat (8) step(0, 8'h00, 1);
        step(1, 8'b0000_1011, 1);
        repeat (10) step(0, 8'h00, 1);
        step(1, 8'hFF, 1);
        repeat (4) step(0, 8'h00, 1);
        chk("pre_rst_busy", busy_m, 1);
        chk("pre_rst_so", so_m, 1);
        #2 n_rst = 1'b0;
        #1 chk_reset_vals("async_rst");
        qm.delete();
        ql.delete();
        left = 0;
        repeat (2) @(posedge clk);
        #1 n_rst = 1'b1;
        repeat (3) step(0, 8'h00, 1);
        for (int k = 0; k < 800; k++)
            step(($urandom_range(0, 2) == 0), 8'($urandom), ($urandom_range(0, 3) != 0));
        repeat (30) step(0, 8'h00, 1);
        chk("drain_m", qm.size(), 0);
        chk("drain_l", ql.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
